layer_scheduler: RTL and testbench

//  Top-level pass sequencer for the layer-multiplexed network. For each accepted training sample it

---
 rtl/layer_scheduler.sv | 175 +++++++++++++++++
 tb/tb_layer_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scheduler.sv
// -----------------------------------------------------------------------------
// layer_scheduler
//
// Pass sequencer for the layer-multiplexed network. Each accepted training
// sample runs a forward sweep over layers 0..LAYER_MAX-1 followed by a
// backward sweep over layers LAYER_MAX-1..0. Every layer index is handed out
// over a valid/ready handshake, and the scheduler then waits for that layer's
// one-cycle done pulse before moving on. Completed samples are counted.
//
// Ports
//   clk                 in   clock, all logic on the rising edge
//   rst                 in   asynchronous active-low reset
//   sample_valid        in   new sample present at the layer controller inputs
//   sample_ready        out  scheduler idle and able to take a sample
//   layer_number        out  forward layer index
//   layer_number_valid  out  forward index valid
//   layer_number_ready  in   layer controller accepts the forward index
//   fwd_done            in   pulse: current forward layer finished
//   bwd_number          out  backward layer index
//   bwd_number_valid    out  backward index valid
//   bwd_number_ready    in   backprop datapath accepts the backward index
//   bwd_done            in   pulse: current backward layer finished
//   direction           out  0 = forward phase / idle, 1 = backward phase
//   busy                out  high whenever a pass is in progress
//   sample_count        out  completed samples, wraps modulo 2**SAMPLE_COUNT_WIDTH
//   protocol_error      out  sticky: a done pulse arrived outside its wait state
// -----------------------------------------------------------------------------
module layer_scheduler #(
   parameter int LAYER_ADDR_WIDTH   = 2,
   parameter int LAYER_MAX          = 3,
   parameter int SAMPLE_COUNT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic [LAYER_ADDR_WIDTH-1:0]   layer_number,
   output logic                          layer_number_valid,
   input  logic                          layer_number_ready,
   input  logic                          fwd_done,
   output logic [LAYER_ADDR_WIDTH-1:0]   bwd_number,
   output logic                          bwd_number_valid,
   input  logic                          bwd_number_ready,
   input  logic                          bwd_done,
   output logic                          direction,
   output logic                          busy,
   output logic [SAMPLE_COUNT_WIDTH-1:0] sample_count,
   output logic                          protocol_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FWD_ISSUE,
      S_FWD_WAIT,
      S_BWD_ISSUE,
      S_BWD_WAIT,
      S_DONE
   } state_t;

   // Index of the deepest layer; the forward sweep turns around here.
   localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);

   state_t                          state;
   state_t                          state_nxt;
   logic [LAYER_ADDR_WIDTH-1:0]     layer_cnt;
   logic [LAYER_ADDR_WIDTH-1:0]     layer_cnt_nxt;
   logic [SAMPLE_COUNT_WIDTH-1:0]   sample_count_nxt;
   logic                            protocol_error_nxt;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         layer_cnt      <= '0;
         sample_count   <= '0;
         protocol_error <= 1'b0;
      end else begin
         state          <= state_nxt;
         layer_cnt      <= layer_cnt_nxt;
         sample_count   <= sample_count_nxt;
         protocol_error <= protocol_error_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets its hold value first so no path through the case
   // statement leaves one unassigned, which would infer a latch.
   always_comb begin
      state_nxt        = state;
      layer_cnt_nxt    = layer_cnt;
      sample_count_nxt = sample_count;

      case (state)
         S_IDLE: begin
            if (sample_valid) begin
               state_nxt     = S_FWD_ISSUE;
               layer_cnt_nxt = '0;
            end
         end

         S_FWD_ISSUE: begin
            if (layer_number_ready) begin
               state_nxt = S_FWD_WAIT;
            end
         end

         S_FWD_WAIT: begin
            if (fwd_done) begin
               if (layer_cnt == LAST_LAYER) begin
                  // Counter stays on the last layer: the backward sweep
                  // starts from the same index.
                  state_nxt = S_BWD_ISSUE;
               end else begin
                  state_nxt     = S_FWD_ISSUE;
                  layer_cnt_nxt = layer_cnt + LAYER_ADDR_WIDTH'(1);
               end
            end
         end

         S_BWD_ISSUE: begin
            if (bwd_number_ready) begin
               state_nxt = S_BWD_WAIT;
            end
         end

         S_BWD_WAIT: begin
            if (bwd_done) begin
               if (layer_cnt == '0) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt     = S_BWD_ISSUE;
                  layer_cnt_nxt = layer_cnt - LAYER_ADDR_WIDTH'(1);
               end
            end
         end

         S_DONE: begin
            sample_count_nxt = sample_count + SAMPLE_COUNT_WIDTH'(1);
            state_nxt        = S_IDLE;
         end

         default: begin
            state_nxt     = S_IDLE;
            layer_cnt_nxt = '0;
         end
      endcase
   end

   // A done pulse only counts in its own wait state. A pulse arriving in the
   // same cycle as the index handshake is still in the issue state, so it is
   // flagged and discarded here rather than special-cased.
   assign protocol_error_nxt = protocol_error
                             | (fwd_done && (state != S_FWD_WAIT))
                             | (bwd_done && (state != S_BWD_WAIT));

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state only, so they follow reset in the
   // same cycle and never depend combinationally on the handshake inputs.
   // ---------------------------------------------------------------------------
   assign sample_ready       = (state == S_IDLE);
   assign busy               = (state != S_IDLE);
   assign layer_number_valid = (state == S_FWD_ISSUE);
   assign bwd_number_valid   = (state == S_BWD_ISSUE);
   assign layer_number       = layer_cnt;
   assign bwd_number         = layer_cnt;
   assign direction          = (state == S_BWD_ISSUE) || (state == S_BWD_WAIT) ||
                               (state == S_DONE);

endmodule

// File: tb/tb_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_layer_scheduler
//
// Inputs are driven just after the falling edge and outputs are compared at
// the same point, half a cycle away from the rising edge the DUT acts on.
// A second instance with a 2-bit sample counter shares all inputs and is used
// for the counter wrap check.
// -----------------------------------------------------------------------------
module tb_layer_scheduler;

   localparam int LAW = 2;
   localparam int LM  = 3;
   localparam int SCW = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           sample_valid;
   logic           sample_ready;
   logic [LAW-1:0] layer_number;
   logic           layer_number_valid;
   logic           layer_number_ready;
   logic           fwd_done;
   logic [LAW-1:0] bwd_number;
   logic           bwd_number_valid;
   logic           bwd_number_ready;
   logic           bwd_done;
   logic           direction;
   logic           busy;
   logic [SCW-1:0] sample_count;
   logic           protocol_error;

   // Outputs of the narrow-counter instance
   logic           w_sample_ready;
   logic [LAW-1:0] w_layer_number;
   logic           w_layer_number_valid;
   logic [LAW-1:0] w_bwd_number;
   logic           w_bwd_number_valid;
   logic           w_direction;
   logic           w_busy;
   logic [1:0]     w_sample_count;
   logic           w_protocol_error;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_count;

   always #5 clk = ~clk;

   layer_scheduler #(
      .LAYER_ADDR_WIDTH   (LAW),
      .LAYER_MAX          (LM),
      .SAMPLE_COUNT_WIDTH (SCW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .sample_valid       (sample_valid),
      .sample_ready       (sample_ready),
      .layer_number       (layer_number),
      .layer_number_valid (layer_number_valid),
      .layer_number_ready (layer_number_ready),
      .fwd_done           (fwd_done),
      .bwd_number         (bwd_number),
      .bwd_number_valid   (bwd_number_valid),
      .bwd_number_ready   (bwd_number_ready),
      .bwd_done           (bwd_done),
      .direction          (direction),
      .busy               (busy),
      .sample_count       (sample_count),
      .protocol_error     (protocol_error)
   );

   layer_scheduler #(
      .LAYER_ADDR_WIDTH   (LAW),
      .LAYER_MAX          (LM),
      .SAMPLE_COUNT_WIDTH (2)
   ) dut_wrap (
      .clk                (clk),
      .rst                (rst),
      .sample_valid       (sample_valid),
      .sample_ready       (w_sample_ready),
      .layer_number       (w_layer_number),
      .layer_number_valid (w_layer_number_valid),
      .layer_number_ready (layer_number_ready),
      .fwd_done           (fwd_done),
      .bwd_number         (w_bwd_number),
      .bwd_number_valid   (w_bwd_number_valid),
      .bwd_number_ready   (bwd_number_ready),
      .bwd_done           (bwd_done),
      .direction          (w_direction),
      .busy               (w_busy),
      .sample_count       (w_sample_count),
      .protocol_error     (w_protocol_error)
   );

   // One cycle of stimulus plus the outputs expected during that cycle.
   // dir = -1 means direction is not compared in that cycle.
   typedef struct {
      logic        sv;
      logic        lnr;
      logic        fd;
      logic        bnr;
      logic        bd;
      logic        sr;
      logic        lv;
      logic [1:0]  ln;
      logic        bv;
      logic [1:0]  bn;
      int          dir;
      logic        busy;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   task automatic wait_lv();
      int k = 0;
      while (!layer_number_valid && k < 20) begin
         next();
         k++;
      end
      check("fwd_valid_arrives", {31'd0, layer_number_valid}, 32'd1);
   endtask

   task automatic wait_bv();
      int k = 0;
      while (!bwd_number_valid && k < 20) begin
         next();
         k++;
      end
      check("bwd_valid_arrives", {31'd0, bwd_number_valid}, 32'd1);
   endtask

   // One complete pass starting from IDLE at a falling edge, ready tied high.
   //   stray_bwd : bwd_done pulse during the first FWD_WAIT
   //   hold_sv   : leave sample_valid high for the whole pass
   //   early_fwd : fwd_done in the same cycle as the layer-1 handshake
   task automatic do_pass(input bit stray_bwd, input bit hold_sv, input bit early_fwd);
      sample_valid = 1'b1;
      check("pass_start_ready", {31'd0, sample_ready}, 32'd1);
      next();
      if (!hold_sv) sample_valid = 1'b0;
      check("pass_busy", {31'd0, busy}, 32'd1);

      for (int i = 0; i < LM; i++) begin
         wait_lv();
         check("fwd_index", {30'd0, layer_number}, i);
         check("fwd_dir", {31'd0, direction}, 32'd0);
         check("fwd_sample_ready", {31'd0, sample_ready}, 32'd0);
         if (early_fwd && i == 1) fwd_done = 1'b1;
         next();
         fwd_done = 1'b0;
         check("fwd_wait_valid_low", {31'd0, layer_number_valid}, 32'd0);
         if (early_fwd && i == 1) begin
            check("early_done_error", {31'd0, protocol_error}, 32'd1);
            next();
            check("early_done_no_advance", {31'd0, layer_number_valid | bwd_number_valid}, 32'd0);
         end
         if (stray_bwd && i == 0) bwd_done = 1'b1;
         next();
         bwd_done = 1'b0;
         fwd_done = 1'b1;
         next();
         fwd_done = 1'b0;
      end

      for (int i = LM - 1; i >= 0; i--) begin
         wait_bv();
         check("bwd_index", {30'd0, bwd_number}, i);
         check("bwd_dir", {31'd0, direction}, 32'd1);
         next();
         check("bwd_wait_valid_low", {31'd0, bwd_number_valid}, 32'd0);
         next();
         bwd_done = 1'b1;
         next();
         bwd_done = 1'b0;
      end

      // DONE cycle
      check("done_busy", {31'd0, busy}, 32'd1);
      check("done_not_ready", {31'd0, sample_ready}, 32'd0);
      exp_count++;
      next();
      check("idle_after_done", {31'd0, busy}, 32'd0);
      check("sample_count", {16'd0, sample_count}, exp_count);
      check("wrap_count", {30'd0, w_sample_count}, exp_count % 4);
   endtask

   initial begin
      rst                = 1'b0;
      sample_valid       = 1'b0;
      layer_number_ready = 1'b1;
      fwd_done           = 1'b0;
      bwd_number_ready   = 1'b1;
      bwd_done           = 1'b0;
      exp_count          = 0;

      // Full pass, fwd_done / bwd_done three cycles after each handshake.
      //              sv lnr fd bnr bd  sr lv ln bv bn dir busy cnt
      vecs.push_back('{1, 1, 0, 1, 0,  1, 0, 0, 0, 0,  0, 0, 0}); // IDLE accept
      vecs.push_back('{0, 1, 0, 1, 0,  0, 1, 0, 0, 0,  0, 1, 0}); // issue L0
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 1, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0}); // fwd_done
      vecs.push_back('{0, 1, 0, 1, 0,  0, 1, 1, 0, 0,  0, 1, 0}); // issue L1
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 1, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 1, 2, 0, 0,  0, 1, 0}); // issue L2
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 1, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 1, 2,  1, 1, 0}); // bwd L2
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 1,  0, 0, 0, 0, 0,  1, 1, 0}); // bwd_done
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 1, 1,  1, 1, 0}); // bwd L1
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 1,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 1, 0,  1, 1, 0}); // bwd L0
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 1,  0, 0, 0, 0, 0,  1, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 0, 0, -1, 1, 0}); // DONE
      vecs.push_back('{0, 1, 0, 1, 0,  1, 0, 0, 0, 0,  0, 0, 1}); // IDLE

      // Reset values while reset is held
      #1;
      check("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fwd_valid", {31'd0, layer_number_valid}, 32'd0);
      check("rst_bwd_valid", {31'd0, bwd_number_valid}, 32'd0);
      check("rst_count", {16'd0, sample_count}, 32'd0);
      check("rst_error", {31'd0, protocol_error}, 32'd0);
      next();
      rst = 1'b1;

      // Table-driven full pass
      foreach (vecs[i]) begin
         next();
         sample_valid       = vecs[i].sv;
         layer_number_ready = vecs[i].lnr;
         fwd_done           = vecs[i].fd;
         bwd_number_ready   = vecs[i].bnr;
         bwd_done           = vecs[i].bd;
         check($sformatf("vec%0d_sample_ready", i), {31'd0, sample_ready}, {31'd0, vecs[i].sr});
         check($sformatf("vec%0d_fwd_valid", i), {31'd0, layer_number_valid}, {31'd0, vecs[i].lv});
         if (vecs[i].lv)
            check($sformatf("vec%0d_fwd_index", i), {30'd0, layer_number}, {30'd0, vecs[i].ln});
         check($sformatf("vec%0d_bwd_valid", i), {31'd0, bwd_number_valid}, {31'd0, vecs[i].bv});
         if (vecs[i].bv)
            check($sformatf("vec%0d_bwd_index", i), {30'd0, bwd_number}, {30'd0, vecs[i].bn});
         if (vecs[i].dir >= 0)
            check($sformatf("vec%0d_direction", i), {31'd0, direction}, vecs[i].dir);
         check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
         check($sformatf("vec%0d_count", i), {16'd0, sample_count}, {16'd0, vecs[i].cnt});
      end

      // Backpressure on forward layer 1, then reset in the middle of the pass
      next();
      sample_valid = 1'b1;
      next();
      sample_valid = 1'b0;               // FWD_ISSUE layer 0, handshake
      next();                            // FWD_WAIT
      fwd_done = 1'b1;
      next();
      fwd_done = 1'b0;                   // FWD_ISSUE layer 1
      layer_number_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid_held", {31'd0, layer_number_valid}, 32'd1);
         check("bp_index_held", {30'd0, layer_number}, 32'd1);
         next();
      end
      check("bp_valid_after_stall", {31'd0, layer_number_valid}, 32'd1);
      check("bp_index_after_stall", {30'd0, layer_number}, 32'd1);
      layer_number_ready = 1'b1;
      next();
      check("bp_released", {31'd0, layer_number_valid}, 32'd0);
      check("bp_released_busy", {31'd0, busy}, 32'd1);

      rst = 1'b0;
      #1;
      check("midrst_sample_ready", {31'd0, sample_ready}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_fwd_valid", {31'd0, layer_number_valid}, 32'd0);
      check("midrst_bwd_valid", {31'd0, bwd_number_valid}, 32'd0);
      check("midrst_index", {30'd0, layer_number}, 32'd0);
      check("midrst_direction", {31'd0, direction}, 32'd0);
      check("midrst_count", {16'd0, sample_count}, 32'd0);
      next();
      rst = 1'b1;
      exp_count = 0;

      // Stray pulses: fwd_done in IDLE, bwd_done in FWD_WAIT, early fwd_done
      check("stray_error_clear", {31'd0, protocol_error}, 32'd0);
      fwd_done = 1'b1;
      next();
      fwd_done = 1'b0;
      check("stray_idle_error", {31'd0, protocol_error}, 32'd1);
      check("stray_idle_stays", {31'd0, busy}, 32'd0);
      do_pass(1'b1, 1'b0, 1'b1);
      check("stray_error_sticky", {31'd0, protocol_error}, 32'd1);

      rst = 1'b0;
      next();
      rst = 1'b1;
      exp_count = 0;

      // Busy reject: sample_valid held through two passes
      do_pass(1'b0, 1'b1, 1'b0);
      do_pass(1'b0, 1'b1, 1'b0);
      sample_valid = 1'b0;
      check("two_pass_count", {16'd0, sample_count}, 32'd2);
      check("clean_no_error", {31'd0, protocol_error}, 32'd0);

      // Wrap of the 2-bit counter after five passes
      for (int p = 0; p < 3; p++) do_pass(1'b0, 1'b0, 1'b0);
      check("five_pass_count", {16'd0, sample_count}, 32'd5);
      check("wrap_five_passes", {30'd0, w_sample_count}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
